control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-003 isr  input  16  instruction register contents from the datapath.
REQ-004 mem_ready  input  1  memory completion strobe for the current read/write.
REQ-005 mem_rd, mem_wr  output  1 each  memory read/write request; address is MAR, write data is MDR.
REQ-006 funsel, rsel  output  3 each  ALU function (0 zero,1 pass,2 add,3 neg,4 or,5 not,6 inc,7 dec) and register select.
REQ-007 lsp, lpc, lmdr, lmar, lisr, ly, wrr  output  1 each  register load enables.
REQ-008 spmar, pcmar, mdrz, mdrm  output  1 each  MAR/MDR input source selects.
REQ-009 tr, tsp, tpc, tmdr, tisr  output  1 each  X-bus drivers.
REQ-010 sflag, cc  output  1 each  flag update; branch qualification of lpc.
REQ-011 halt  output  1  high while in HALT.

Function
REQ-012 Opcode isr[15:12]: 0-8 BR (condition = opcode, offset isr[11:0]); 9 ALU (isr[11:9] funsel, isr[8:6] rd, isr[5:3] rt); 10 LDI rd; 11 PUSH rs; 12 POP rd; 13-14 NOP; 15 HALT.
REQ-013 Outputs SHALL be decoded from current state only, except lmdr/mdrm/state advance in wait states, which also depend on mem_ready; unlisted outputs are 0.
REQ-014 At most one of tr/tsp/tpc/tmdr/tisr SHALL be high in any cycle; at most one of spmar/pcmar and of mdrz/mdrm.
REQ-015 F0: pcmar, lmar, tpc, funsel=6, lpc (MAR takes old PC, PC increments).
REQ-016 F1: mem_rd=1; stays in F1 while mem_ready=0; when mem_ready=1: mdrm, lmdr, then go to F2.
REQ-017 F2: lisr; then DEC. DEC: no outputs; branch on opcode. NOP returns to F0.
REQ-018 BR: BR0 tisr, ly; BR1 tpc, funsel=2, lpc, cc=1; then F0. PC changes only if the datapath condition is true.
REQ-019 ALU: AL0 rsel=rt, tr, ly; AL1 rsel=rd, tr, funsel=isr[11:9], wrr, sflag; then F0.
REQ-020 LDI: LI0 same outputs as F0; LI1 read wait as in F1; LI2 tmdr, funsel=1, rsel=rd, wrr; then F0.
REQ-021 PUSH: PU0 tsp, funsel=7, lsp; PU1 spmar, lmar, rsel=rs, tr, funsel=1, mdrz, lmdr; PU2 mem_wr=1 until mem_ready=1; then F0.
REQ-022 POP: PO0 spmar, lmar, tsp, funsel=6, lsp; PO1 read wait as in F1; PO2 tmdr, funsel=1, rsel=rd, wrr; then F0.
REQ-023 HALT: halt=1, all other outputs 0; exits only on reset.
REQ-024 mem_rd/mem_wr SHALL deassert in the cycle after mem_ready is sampled high; mem_ready outside a wait state is ignored.
REQ-025 Wait states have no timeout; a stalled memory holds the FSM indefinitely.

Reset
REQ-026 While reset=1 all outputs SHALL be 0, including mem_rd/mem_wr; at the next edge the state is F0.
REQ-027 Reset during any state, including wait states, SHALL abort the instruction with no further loads.

Configuration
REQ-028 With CU_STACK_EN defined: PUSH/POP per REQ-021/022.
REQ-029 Without CU_STACK_EN: opcodes 11/12 execute as NOP (DEC -> F0) and the PU/PO states are not built.

Structure
REQ-030 Package cu_pkg: state encoding, opcode constants, funsel constants.
REQ-031 One sub-module, cu_decode: combinational state-to-control-vector decoder; the FSM register stays in control_unit.

Verification
REQ-032 Reset, then mem_ready=1 each cycle, isr=0x9A88 (op 9, funsel 5, rd 2, rt 1) -> F0,F1,F2,DEC,AL0,AL1; in AL1: funsel=5, rsel=2, wrr=1, sflag=1.
REQ-033 isr=0x1FFE -> BR0 tisr=ly=1; BR1 tpc=lpc=cc=1, funsel=2.
REQ-034 F1 with mem_ready low for 3 cycles -> mem_rd high for 4 cycles, lmdr only in the 4th, mem_rd=0 in the following cycle.
REQ-035 isr=0xB0C0 with CU_STACK_EN -> PU0 funsel=7, lsp; PU2 mem_wr until ready. Without CU_STACK_EN -> DEC then F0.
REQ-036 isr=0xF000 -> halt=1 held for 10 cycles; reset -> F0 with all outputs 0 during reset.
REQ-037 Reset asserted in LI1 with mem_rd=1 -> mem_rd=0 in the same cycle; after reset the FSM is in F0 with no wrr pulse.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types for the control unit: state encoding, opcodes, ALU function codes, control vector.
// CU_STACK_EN adds the PUSH/POP states and their dispatch.
package cu_pkg;

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_DEC,
    S_BR0, S_BR1,
    S_AL0, S_AL1,
    S_LI0, S_LI1, S_LI2,
`ifdef CU_STACK_EN
    S_PU0, S_PU1, S_PU2,
    S_PO0, S_PO1, S_PO2,
`endif
    S_HALT
  } state_e;

  localparam logic [3:0] OP_BR_MAX = 4'd8;
  localparam logic [3:0] OP_ALU    = 4'd9;
  localparam logic [3:0] OP_LDI    = 4'd10;
  localparam logic [3:0] OP_PUSH   = 4'd11;
  localparam logic [3:0] OP_POP    = 4'd12;
  localparam logic [3:0] OP_HALT   = 4'd15;

  localparam logic [2:0] FN_ZERO = 3'd0;
  localparam logic [2:0] FN_PASS = 3'd1;
  localparam logic [2:0] FN_ADD  = 3'd2;
  localparam logic [2:0] FN_NEG  = 3'd3;
  localparam logic [2:0] FN_OR   = 3'd4;
  localparam logic [2:0] FN_NOT  = 3'd5;
  localparam logic [2:0] FN_INC  = 3'd6;
  localparam logic [2:0] FN_DEC  = 3'd7;

  typedef struct packed {
    logic       halt;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] funsel;
    logic [2:0] rsel;
    logic       lsp, lpc, lmdr, lmar, lisr, ly, wrr;
    logic       spmar, pcmar, mdrz, mdrm;
    logic       tr, tsp, tpc, tmdr, tisr;
    logic       sflag, cc;
  } ctrl_t;

  // First execute state for a decoded opcode; NOPs (and disabled stack ops) refetch.
  function automatic state_e dispatch(input logic [3:0] op);
    state_e nxt;
    nxt = S_F0;
    if (op <= OP_BR_MAX)   nxt = S_BR0;
    else if (op == OP_ALU) nxt = S_AL0;
    else if (op == OP_LDI) nxt = S_LI0;
`ifdef CU_STACK_EN
    else if (op == OP_PUSH) nxt = S_PU0;
    else if (op == OP_POP)  nxt = S_PO0;
`endif
    else if (op == OP_HALT) nxt = S_HALT;
    return nxt;
  endfunction

endpackage

// File: rtl/cu_if.sv
// Control unit <-> datapath/memory bundle: instruction, memory handshake and all control strobes.
interface cu_if;
  logic [15:0] isr;
  logic        mem_ready;
  logic        mem_rd, mem_wr;
  logic [2:0]  funsel, rsel;
  logic        lsp, lpc, lmdr, lmar, lisr, ly, wrr;
  logic        spmar, pcmar, mdrz, mdrm;
  logic        tr, tsp, tpc, tmdr, tisr;
  logic        sflag, cc, halt;

  modport master (
    input  isr, mem_ready,
    output mem_rd, mem_wr, funsel, rsel, lsp, lpc, lmdr, lmar, lisr, ly, wrr,
           spmar, pcmar, mdrz, mdrm, tr, tsp, tpc, tmdr, tisr, sflag, cc, halt
  );

  modport slave (
    output isr, mem_ready,
    input  mem_rd, mem_wr, funsel, rsel, lsp, lpc, lmdr, lmar, lisr, ly, wrr,
           spmar, pcmar, mdrz, mdrm, tr, tsp, tpc, tmdr, tisr, sflag, cc, halt
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational state -> control vector decoder; only wait states look at mem_ready.
// CU_STACK_EN enables the PUSH/POP decode arms.
module cu_decode
  import cu_pkg::*;
(
  input  state_e     state_i,
  input  logic [2:0] fn_i,
  input  logic [2:0] rd_i,
  input  logic [2:0] rt_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_F0, S_LI0: begin
        ctrl_o.pcmar  = 1'b1;
        ctrl_o.lmar   = 1'b1;
        ctrl_o.tpc    = 1'b1;
        ctrl_o.funsel = FN_INC;
        ctrl_o.lpc    = 1'b1;
      end
`ifdef CU_STACK_EN
      S_F1, S_LI1, S_PO1: begin
`else
      S_F1, S_LI1: begin
`endif
        ctrl_o.mem_rd = 1'b1;
        ctrl_o.mdrm   = mem_ready_i;
        ctrl_o.lmdr   = mem_ready_i;
      end
      S_F2:  ctrl_o.lisr = 1'b1;
      S_BR0: begin
        ctrl_o.tisr = 1'b1;
        ctrl_o.ly   = 1'b1;
      end
      S_BR1: begin
        ctrl_o.tpc    = 1'b1;
        ctrl_o.funsel = FN_ADD;
        ctrl_o.lpc    = 1'b1;
        ctrl_o.cc     = 1'b1;
      end
      S_AL0: begin
        ctrl_o.rsel = rt_i;
        ctrl_o.tr   = 1'b1;
        ctrl_o.ly   = 1'b1;
      end
      S_AL1: begin
        ctrl_o.rsel   = rd_i;
        ctrl_o.tr     = 1'b1;
        ctrl_o.funsel = fn_i;
        ctrl_o.wrr    = 1'b1;
        ctrl_o.sflag  = 1'b1;
      end
`ifdef CU_STACK_EN
      S_LI2, S_PO2: begin
`else
      S_LI2: begin
`endif
        ctrl_o.tmdr   = 1'b1;
        ctrl_o.funsel = FN_PASS;
        ctrl_o.rsel   = rd_i;
        ctrl_o.wrr    = 1'b1;
      end
`ifdef CU_STACK_EN
      S_PU0: begin
        ctrl_o.tsp    = 1'b1;
        ctrl_o.funsel = FN_DEC;
        ctrl_o.lsp    = 1'b1;
      end
      // PUSH source register shares the rd field (isr[8:6]).
      S_PU1: begin
        ctrl_o.spmar  = 1'b1;
        ctrl_o.lmar   = 1'b1;
        ctrl_o.rsel   = rd_i;
        ctrl_o.tr     = 1'b1;
        ctrl_o.funsel = FN_PASS;
        ctrl_o.mdrz   = 1'b1;
        ctrl_o.lmdr   = 1'b1;
      end
      S_PU2: ctrl_o.mem_wr = 1'b1;
      S_PO0: begin
        ctrl_o.spmar  = 1'b1;
        ctrl_o.lmar   = 1'b1;
        ctrl_o.tsp    = 1'b1;
        ctrl_o.funsel = FN_INC;
        ctrl_o.lsp    = 1'b1;
      end
`endif
      S_HALT:  ctrl_o.halt = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit FSM: fetch, decode and execute BR/ALU/LDI/HALT (PUSH/POP with CU_STACK_EN).
// Outputs are a decode of the current state, forced to zero while reset is high.
module control_unit
  import cu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  cu_if.master bus
);

  state_e     state_q;
  ctrl_t      dec_ctrl;
  ctrl_t      ctrl;
  logic [3:0] opcode;
  logic       unused_isr_bits;

  assign opcode          = bus.isr[15:12];
  assign unused_isr_bits = ^bus.isr[2:0];

  // Wait states hold indefinitely until memory answers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_F0;
    end else begin
      case (state_q)
        S_F0:  state_q <= S_F1;
        S_F1:  if (bus.mem_ready) state_q <= S_F2;
        S_F2:  state_q <= S_DEC;
        S_DEC: state_q <= dispatch(opcode);
        S_BR0: state_q <= S_BR1;
        S_AL0: state_q <= S_AL1;
        S_LI0: state_q <= S_LI1;
        S_LI1: if (bus.mem_ready) state_q <= S_LI2;
`ifdef CU_STACK_EN
        S_PU0: state_q <= S_PU1;
        S_PU1: state_q <= S_PU2;
        S_PU2: if (bus.mem_ready) state_q <= S_F0;
        S_PO0: state_q <= S_PO1;
        S_PO1: if (bus.mem_ready) state_q <= S_PO2;
`endif
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_F0;
      endcase
    end
  end

  cu_decode u_decode (
    .state_i     (state_q),
    .fn_i        (bus.isr[11:9]),
    .rd_i        (bus.isr[8:6]),
    .rt_i        (bus.isr[5:3]),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (dec_ctrl)
  );

  assign ctrl = reset ? '0 : dec_ctrl;

  assign bus.halt   = ctrl.halt;
  assign bus.mem_rd = ctrl.mem_rd;
  assign bus.mem_wr = ctrl.mem_wr;
  assign bus.funsel = ctrl.funsel;
  assign bus.rsel   = ctrl.rsel;
  assign bus.lsp    = ctrl.lsp;
  assign bus.lpc    = ctrl.lpc;
  assign bus.lmdr   = ctrl.lmdr;
  assign bus.lmar   = ctrl.lmar;
  assign bus.lisr   = ctrl.lisr;
  assign bus.ly     = ctrl.ly;
  assign bus.wrr    = ctrl.wrr;
  assign bus.spmar  = ctrl.spmar;
  assign bus.pcmar  = ctrl.pcmar;
  assign bus.mdrz   = ctrl.mdrz;
  assign bus.mdrm   = ctrl.mdrm;
  assign bus.tr     = ctrl.tr;
  assign bus.tsp    = ctrl.tsp;
  assign bus.tpc    = ctrl.tpc;
  assign bus.tmdr   = ctrl.tmdr;
  assign bus.tisr   = ctrl.tisr;
  assign bus.sflag  = ctrl.sflag;
  assign bus.cc     = ctrl.cc;

endmodule
